// File: rtl/seven_seg_reader.sv
// seven_seg_reader: watches an active-low 7-segment bus, waits for the pattern to
// settle, then decodes it back to a hex digit (or flags an illegal glyph) and
// delivers each new stable glyph once over a valid/ready handshake.
module seven_seg_reader #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] seg_in,
    output logic [3:0] digit_out,
    output logic       digit_err,
    output logic       digit_valid,
    input  logic       digit_ready
);

    typedef enum logic {
        TRACK,
        HOLD
    } state_t;

    localparam logic [CNT_W-1:0] STABLE_MAX = CNT_W'(STABLE_CYCLES);
    localparam logic [6:0]       BLANK      = 7'h7F;

    logic [6:0]       seg_q;
    logic [CNT_W-1:0] cnt;
    logic             stable;
    logic [6:0]       last_pat;
    state_t           state;

    logic [3:0]       dec_digit;
    logic             dec_err;

    state_t           state_nx;
    logic [6:0]       last_pat_nx;
    logic [3:0]       digit_out_nx;
    logic             digit_err_nx;
    logic             digit_valid_nx;

    assign stable = (cnt == STABLE_MAX);

    // Decode the registered segment pattern back into a hex value; blank and
    // unknown patterns both report 0 here, blank is filtered out by the FSM.
    always_comb begin
        dec_digit = 4'h0;
        dec_err   = 1'b0;
        case (seg_q)
            7'h40: dec_digit = 4'h0;
            7'h79: dec_digit = 4'h1;
            7'h24: dec_digit = 4'h2;
            7'h30: dec_digit = 4'h3;
            7'h19: dec_digit = 4'h4;
            7'h12: dec_digit = 4'h5;
            7'h02: dec_digit = 4'h6;
            7'h78: dec_digit = 4'h7;
            7'h00: dec_digit = 4'h8;
            7'h10: dec_digit = 4'h9;
            7'h08: dec_digit = 4'hA;
            7'h03: dec_digit = 4'hB;
            7'h46: dec_digit = 4'hC;
            7'h21: dec_digit = 4'hD;
            7'h06: dec_digit = 4'hE;
            7'h0E: dec_digit = 4'hF;
            BLANK: dec_digit = 4'h0;
            default: dec_err = 1'b1;
        endcase
    end

    // Stability tracker: any change restarts the count, otherwise count up and
    // saturate so a long-held pattern stays "stable" indefinitely.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            seg_q <= BLANK;
            cnt   <= '0;
        end else if (seg_in != seg_q) begin
            seg_q <= seg_in;
            cnt   <= '0;
        end else if (cnt != STABLE_MAX) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Next-state logic: emit a new stable glyph from TRACK, wait in HOLD until the
    // consumer takes it. A stable blank only re-arms repeat suppression.
    always_comb begin
        state_nx       = state;
        last_pat_nx    = last_pat;
        digit_out_nx   = digit_out;
        digit_err_nx   = digit_err;
        digit_valid_nx = digit_valid;
        case (state)
            TRACK: begin
                if (stable && (seg_q != last_pat)) begin
                    last_pat_nx = seg_q;
                    if (seg_q != BLANK) begin
                        digit_out_nx   = dec_digit;
                        digit_err_nx   = dec_err;
                        digit_valid_nx = 1'b1;
                        state_nx       = HOLD;
                    end
                end
            end
            HOLD: begin
                if (digit_ready) begin
                    digit_valid_nx = 1'b0;
                    state_nx       = TRACK;
                end
            end
            default: state_nx = TRACK;
        endcase
    end

    // FSM and output registers; a reset mid-HOLD discards the pending glyph.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= TRACK;
            last_pat    <= BLANK;
            digit_out   <= 4'h0;
            digit_err   <= 1'b0;
            digit_valid <= 1'b0;
        end else begin
            state       <= state_nx;
            last_pat    <= last_pat_nx;
            digit_out   <= digit_out_nx;
            digit_err   <= digit_err_nx;
            digit_valid <= digit_valid_nx;
        end
    end

endmodule

// File: tb/tb_seven_seg_reader.sv
// tb_seven_seg_reader: table of single-glyph decodes plus hand-written sequences
// for glitches, back-pressure, repeat suppression and asynchronous reset.
module tb_seven_seg_reader;

    logic       clk;
    logic       rst;
    logic [6:0] seg_in;
    logic [3:0] digit_out;
    logic       digit_err;
    logic       digit_valid;
    logic       digit_ready;

    int tests_run;
    int tests_failed;

    int         edge_idx;
    int         pulses;
    int         first_edge;
    logic [3:0] cap_digit;
    logic       cap_err;
    logic [3:0] last_digit;

    typedef struct {
        logic [6:0] seg;
        logic [3:0] digit;
        logic       err;
    } vec_t;

    vec_t vecs[19];

    seven_seg_reader #(
        .STABLE_CYCLES(4),
        .CNT_W(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .seg_in(seg_in),
        .digit_out(digit_out),
        .digit_err(digit_err),
        .digit_valid(digit_valid),
        .digit_ready(digit_ready)
    );

    // Free-running 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compare one observed value against its expected value and tally the result
    task automatic checkOutput(input string name, input int actual, input int expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Start a fresh observation window for pulse counting
    task automatic clearObs();
        edge_idx   = 0;
        pulses     = 0;
        first_edge = -1;
        cap_digit  = 4'h0;
        cap_err    = 1'b0;
        last_digit = 4'h0;
    endtask

    // Hold a segment pattern and ready level for a number of edges, sampling 1 ns
    // after each rising edge and recording every cycle valid is seen high
    task automatic applyStimulus(input logic [6:0] seg, input int cycles, input logic rdy);
        seg_in      = seg;
        digit_ready = rdy;
        repeat (cycles) begin
            @(posedge clk);
            #1;
            edge_idx++;
            if (digit_valid === 1'b1) begin
                if (pulses == 0) begin
                    first_edge = edge_idx;
                    cap_digit  = digit_out;
                    cap_err    = digit_err;
                end
                last_digit = digit_out;
                pulses++;
            end
        end
    endtask

    // Main test sequence
    initial begin
        tests_run    = 0;
        tests_failed = 0;

        vecs[0]  = '{7'h40, 4'h0, 1'b0};
        vecs[1]  = '{7'h79, 4'h1, 1'b0};
        vecs[2]  = '{7'h24, 4'h2, 1'b0};
        vecs[3]  = '{7'h30, 4'h3, 1'b0};
        vecs[4]  = '{7'h19, 4'h4, 1'b0};
        vecs[5]  = '{7'h12, 4'h5, 1'b0};
        vecs[6]  = '{7'h02, 4'h6, 1'b0};
        vecs[7]  = '{7'h78, 4'h7, 1'b0};
        vecs[8]  = '{7'h00, 4'h8, 1'b0};
        vecs[9]  = '{7'h10, 4'h9, 1'b0};
        vecs[10] = '{7'h08, 4'hA, 1'b0};
        vecs[11] = '{7'h03, 4'hB, 1'b0};
        vecs[12] = '{7'h46, 4'hC, 1'b0};
        vecs[13] = '{7'h21, 4'hD, 1'b0};
        vecs[14] = '{7'h06, 4'hE, 1'b0};
        vecs[15] = '{7'h0E, 4'hF, 1'b0};
        vecs[16] = '{7'h55, 4'h0, 1'b1};
        vecs[17] = '{7'h7E, 4'h0, 1'b1};
        vecs[18] = '{7'h01, 4'h0, 1'b1};

        // Reset with glyph 2 already on the bus
        rst         = 1'b0;
        seg_in      = 7'h24;
        digit_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_valid", int'(digit_valid), 0);
        checkOutput("reset_digit", int'(digit_out), 0);
        checkOutput("reset_err", int'(digit_err), 0);
        rst = 1'b1;

        // Glyph 2 held 10 cycles: one pulse, 6th edge after reset release
        clearObs();
        applyStimulus(7'h24, 10, 1'b1);
        checkOutput("t1_pulses", pulses, 1);
        checkOutput("t1_edge", first_edge, 6);
        checkOutput("t1_digit", int'(cap_digit), 2);
        checkOutput("t1_err", int'(cap_err), 0);

        // Glyph 1 with a 2-cycle blank glitch: emit only after 5 stable edges
        clearObs();
        applyStimulus(7'h79, 2, 1'b1);
        applyStimulus(7'h7F, 2, 1'b1);
        applyStimulus(7'h79, 10, 1'b1);
        checkOutput("t2_pulses", pulses, 1);
        checkOutput("t2_edge", first_edge, 10);
        checkOutput("t2_digit", int'(cap_digit), 1);

        // Illegal pattern: error flag with digit forced to 0
        clearObs();
        applyStimulus(7'h55, 10, 1'b1);
        checkOutput("t3_pulses", pulses, 1);
        checkOutput("t3_edge", first_edge, 6);
        checkOutput("t3_digit", int'(cap_digit), 0);
        checkOutput("t3_err", int'(cap_err), 1);

        // Back-pressure: 3 held while 4 settles, then 3 accepted and 4 follows
        clearObs();
        applyStimulus(7'h30, 10, 1'b0);
        checkOutput("t4_first_edge", first_edge, 6);
        checkOutput("t4_held_cycles", pulses, 5);
        checkOutput("t4_first_digit", int'(cap_digit), 3);
        applyStimulus(7'h19, 8, 1'b0);
        checkOutput("t4_still_valid", int'(digit_valid), 1);
        checkOutput("t4_frozen_digit", int'(digit_out), 3);
        clearObs();
        applyStimulus(7'h19, 4, 1'b1);
        checkOutput("t4_next_pulses", pulses, 1);
        checkOutput("t4_next_edge", first_edge, 2);
        checkOutput("t4_next_digit", int'(cap_digit), 4);

        // 8, blank, 8: blank re-arms suppression, two emits total
        clearObs();
        applyStimulus(7'h00, 8, 1'b1);
        applyStimulus(7'h7F, 8, 1'b1);
        applyStimulus(7'h00, 8, 1'b1);
        checkOutput("t5_pulses", pulses, 2);
        checkOutput("t5_first_digit", int'(cap_digit), 8);
        checkOutput("t5_second_digit", int'(last_digit), 8);
        clearObs();
        applyStimulus(7'h00, 10, 1'b1);
        checkOutput("t5_no_repeat", pulses, 0);

        // Asynchronous reset while holding glyph C
        clearObs();
        applyStimulus(7'h46, 6, 1'b0);
        checkOutput("t6_valid_before", int'(digit_valid), 1);
        checkOutput("t6_digit_before", int'(digit_out), 12);
        rst = 1'b0;
        #1;
        checkOutput("t6_valid_async", int'(digit_valid), 0);
        checkOutput("t6_digit_async", int'(digit_out), 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        clearObs();
        applyStimulus(7'h46, 10, 1'b1);
        checkOutput("t6_pulses", pulses, 1);
        checkOutput("t6_edge", first_edge, 6);
        checkOutput("t6_digit", int'(cap_digit), 12);

        // Full decode table, each glyph differing from the one before
        for (int i = 0; i < 19; i++) begin
            clearObs();
            applyStimulus(vecs[i].seg, 8, 1'b1);
            checkOutput($sformatf("tbl%0d_pulses", i), pulses, 1);
            checkOutput($sformatf("tbl%0d_edge", i), first_edge, 6);
            checkOutput($sformatf("tbl%0d_digit", i), int'(cap_digit), int'(vecs[i].digit));
            checkOutput($sformatf("tbl%0d_err", i), int'(cap_err), int'(vecs[i].err));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
